// File: rtl/wb_stream_writer.sv
// Wishbone burst master: buffers a 32-bit valid/ready stream in a small FIFO and
// writes it to memory as incrementing bursts from a configured base address.
module wb_stream_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [31:0] cfg_base_i,
  input  logic [23:0] cfg_words_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2, GAP = 2'd3} state_t;

  state_t         state_r, state_s;
  logic [31:0]    addr_r, addr_s;
  logic [23:0]    remaining_r, remaining_s;
  logic [23:0]    total_r, total_s;
  logic [23:0]    accepted_r, accepted_s;
  logic [BW-1:0]  beats_r, beats_s, blen_s;
  logic [AW-1:0]  rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s, rd_next_s;
  logic [CW-1:0]  count_r, count_s, occ_pop_s;
  logic [31:0]    mem_r [FIFO_DEPTH];
  logic [31:0]    head_s, adr_s, dat_s;
  logic [3:0]     sel_s;
  logic [2:0]     cti_s;
  logic           push_s, pop_s, busy_s, done_s, ready_s, cyc_s, stb_s, we_s;

  assign push_s    = s_valid_i && s_ready_o;
  assign pop_s     = (state_r == BURST) && wb_ack_i;
  assign rd_next_s = rd_ptr_r + AW'(pop_s);
  assign occ_pop_s = count_r - CW'(pop_s);

  // FIFO head after this edge; a word pushed into an otherwise empty FIFO falls straight through
  always_comb begin
    if (push_s && (occ_pop_s == CW'(1'b0))) begin
      head_s = s_dat_i;
    end else begin
      head_s = mem_r[rd_next_s];
    end
  end

  // burst length for the next burst: the tail burst may be shorter
  always_comb begin
    if (remaining_r < 24'(BURST_LEN)) begin
      blen_s = BW'(remaining_r);
    end else begin
      blen_s = BW'(BURST_LEN);
    end
  end

  // next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    remaining_s = remaining_r;
    total_s     = total_r;
    accepted_s  = accepted_r + 24'(push_s);
    beats_s     = beats_r;
    rd_ptr_s    = rd_next_s;
    wr_ptr_s    = wr_ptr_r + AW'(push_s);
    count_s     = count_r + CW'(push_s) - CW'(pop_s);
    busy_s      = busy_o;
    done_s      = 1'b0;
    cyc_s       = wb_cyc_o;
    stb_s       = wb_stb_o;
    we_s        = wb_we_o;
    sel_s       = wb_sel_o;
    cti_s       = wb_cti_o;
    adr_s       = wb_adr_o;
    dat_s       = wb_dat_o;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          addr_s      = cfg_base_i;
          remaining_s = cfg_words_i;
          total_s     = cfg_words_i;
          accepted_s  = 24'd0;
          rd_ptr_s    = AW'(1'b0);
          wr_ptr_s    = AW'(1'b0);
          count_s     = CW'(1'b0);
          if (cfg_words_i == 24'd0) begin
            done_s = 1'b1;
          end else begin
            state_s = WAIT;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (32'(count_s) >= 32'(blen_s)) begin
          state_s = BURST;
          beats_s = blen_s;
          cyc_s   = 1'b1;
          stb_s   = 1'b1;
          we_s    = 1'b1;
          sel_s   = 4'hF;
          adr_s   = addr_r;
          dat_s   = head_s;
          cti_s   = (32'(blen_s) == 32'd1) ? 3'b111 : 3'b010;
        end else begin
          state_s = WAIT;
        end
      end
      BURST: begin
        if (wb_ack_i) begin
          addr_s      = addr_r + 32'd4;
          remaining_s = remaining_r - 24'd1;
          beats_s     = beats_r - BW'(1'b1);
          if (32'(beats_r) == 32'd1) begin
            cyc_s = 1'b0;
            stb_s = 1'b0;
            we_s  = 1'b0;
            sel_s = 4'h0;
            cti_s = 3'b000;
            if (remaining_r == 24'd1) begin
              state_s = IDLE;
              done_s  = 1'b1;
              busy_s  = 1'b0;
            end else begin
              state_s = GAP;
            end
          end else begin
            adr_s = addr_r + 32'd4;
            dat_s = head_s;
            cti_s = (32'(beats_r) == 32'd2) ? 3'b111 : 3'b010;
          end
        end else begin
          state_s = BURST;
        end
      end
      GAP: begin
        state_s = WAIT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    ready_s = busy_s && (count_s != CW'(FIFO_DEPTH)) && (accepted_s < total_s);
  end

  // FIFO storage, written on every accepted stream word
  always_ff @(posedge wb_clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_dat_i;
    end
  end

  // state and registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r     <= IDLE;
      addr_r      <= 32'd0;
      remaining_r <= 24'd0;
      total_r     <= 24'd0;
      accepted_r  <= 24'd0;
      beats_r     <= BW'(1'b0);
      rd_ptr_r    <= AW'(1'b0);
      wr_ptr_r    <= AW'(1'b0);
      count_r     <= CW'(1'b0);
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      s_ready_o   <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= 4'h0;
      wb_cti_o    <= 3'b000;
      wb_adr_o    <= 32'd0;
      wb_dat_o    <= 32'd0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      remaining_r <= remaining_s;
      total_r     <= total_s;
      accepted_r  <= accepted_s;
      beats_r     <= beats_s;
      rd_ptr_r    <= rd_ptr_s;
      wr_ptr_r    <= wr_ptr_s;
      count_r     <= count_s;
      busy_o      <= busy_s;
      done_o      <= done_s;
      s_ready_o   <= ready_s;
      wb_cyc_o    <= cyc_s;
      wb_stb_o    <= stb_s;
      wb_we_o     <= we_s;
      wb_sel_o    <= sel_s;
      wb_cti_o    <= cti_s;
      wb_adr_o    <= adr_s;
      wb_dat_o    <= dat_s;
    end
  end
endmodule

// File: tb/tb_wb_stream_writer.sv
// Randomised bench for wb_stream_writer: a Wishbone slave and stream source at the
// falling edge feed a queue-based model of addresses, data, CTI and FIFO occupancy.
module tb_wb_stream_writer;
  localparam int DEPTH0 = 16, BL0 = 8, DEPTH1 = 4, BL1 = 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, ack = 1'b0, use1 = 1'b0;
  logic [31:0] base = 32'd0, s_dat = 32'd0;
  logic [23:0] words = 24'd0;
  logic st0, st1;
  logic busy0, done0, rdy0, we0, cyc0, stb0, busy1, done1, rdy1, we1, cyc1, stb1;
  logic [31:0] adr0, dat0, adr1, dat1;
  logic [3:0] sel0, sel1;
  logic [2:0] cti0, cti1;
  logic busy, done, rdy, we, cyc, stb;
  logic [31:0] adr, dat;
  logic [3:0] sel;
  logic [2:0] cti;

  assign st0 = start & ~use1;
  assign st1 = start & use1;
  assign {busy, done, rdy, we, cyc, stb} = use1 ? {busy1, done1, rdy1, we1, cyc1, stb1}
                                                : {busy0, done0, rdy0, we0, cyc0, stb0};
  assign {adr, dat, sel, cti} = use1 ? {adr1, dat1, sel1, cti1} : {adr0, dat0, sel0, cti0};

  wb_stream_writer #(.FIFO_DEPTH(DEPTH0), .BURST_LEN(BL0)) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(st0), .cfg_base_i(base), .cfg_words_i(words),
    .busy_o(busy0), .done_o(done0), .s_dat_i(s_dat), .s_valid_i(s_valid), .s_ready_o(rdy0),
    .wb_adr_o(adr0), .wb_dat_o(dat0), .wb_sel_o(sel0), .wb_cti_o(cti0), .wb_we_o(we0),
    .wb_cyc_o(cyc0), .wb_stb_o(stb0), .wb_ack_i(ack));

  wb_stream_writer #(.FIFO_DEPTH(DEPTH1), .BURST_LEN(BL1)) dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(st1), .cfg_base_i(base), .cfg_words_i(words),
    .busy_o(busy1), .done_o(done1), .s_dat_i(s_dat), .s_valid_i(s_valid), .s_ready_o(rdy1),
    .wb_adr_o(adr1), .wb_dat_o(dat1), .wb_sel_o(sel1), .wb_cti_o(cti1), .wb_we_o(we1),
    .wb_cyc_o(cyc1), .wb_stb_o(stb1), .wb_ack_i(ack));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, viol = 0, done_cnt = 0, bursts = 0, tick = 0;
  int ack_mode = 0, v_mode = 0, cur_words = 0;
  bit mon_en = 1'b0, prev_busy = 1'b0, prev_cyc = 1'b0, last_acked = 1'b0;
  bit hold_chk = 1'b0, s_taken = 1'b0, saw_full = 1'b0;
  logic [2:0] last_cti = 3'b000;
  logic [66:0] held = 67'd0;
  logic [31:0] adr_q[$], dat_q[$], sent_q[$];
  logic [2:0] cti_q[$];

  // Slave, stream source and per-cycle protocol model, all at the falling edge
  always @(negedge clk) begin
    int occ;
    bit exp_rdy, a;
    if (mon_en) begin
      occ = sent_q.size() - adr_q.size();
      exp_rdy = busy && (occ < (use1 ? DEPTH1 : DEPTH0)) && (sent_q.size() < cur_words);
      if (rdy !== exp_rdy) viol++;
      if (busy && !rdy && (sent_q.size() < cur_words)) saw_full = 1'b1;
      if ((prev_busy && !busy && !done) || (done && busy)) viol++;
      if (done) done_cnt++;
      if (cyc && !prev_cyc) bursts++;
      if (last_acked && (cyc !== (last_cti != 3'b111))) viol++;
      if (hold_chk && (!stb || {adr, dat, cti} !== held)) viol++;
      if (cyc && stb && (we !== 1'b1 || sel !== 4'hF)) viol++;
      if (!cyc && stb) viol++;
      tick++;
      a = 1'b0;
      if (cyc && stb) begin
        case (ack_mode)
          0: a = 1'b1;
          1: a = 1'($urandom_range(0, 1));
          default: a = (tick % 3 == 0);
        endcase
      end else if (ack_mode == 1) begin
        a = 1'($urandom_range(0, 1));
      end
      ack = a;
      last_acked = a && cyc && stb;
      last_cti = cti;
      hold_chk = cyc && stb && !a;
      held = {adr, dat, cti};
      if (last_acked) begin
        adr_q.push_back(adr);
        dat_q.push_back(dat);
        cti_q.push_back(cti);
      end
      if (!s_valid || s_taken) begin
        s_dat = $urandom;
        s_valid = (v_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      s_taken = s_valid && rdy;
      if (s_taken) sent_q.push_back(s_dat);
      prev_busy = busy;
      prev_cyc = cyc;
    end else begin
      ack = 1'b0;
      prev_busy = 1'b0;
      prev_cyc = 1'b0;
      last_acked = 1'b0;
      hold_chk = 1'b0;
      s_taken = 1'b0;
    end
  end

  task automatic kick(input logic [31:0] b, input int n, input int am, input int vm);
    @(negedge clk);
    adr_q.delete(); dat_q.delete(); cti_q.delete(); sent_q.delete();
    viol = 0; done_cnt = 0; bursts = 0; saw_full = 1'b0;
    cur_words = n; ack_mode = am; v_mode = vm;
    base = b; words = 24'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; base = $urandom; words = 24'($urandom);
  endtask

  task automatic run_xfer(input string name, input logic [31:0] b, input int n,
                          input int am, input int vm, input bit interfere);
    int bl, k;
    logic [31:0] exp_a;
    logic [2:0] exp_c;
    bl = use1 ? BL1 : BL0;
    kick(b, n, am, vm);
    if (interfere) begin
      repeat (6) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_mid: got %b expected 1", name, busy); end
      base = 32'h0000_5000; words = 24'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (done_cnt == 0 && k < 4000) begin @(negedge clk); k++; end
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL %s timeout: done_o never pulsed in %0d cycles", name, k); end
    repeat (4) @(negedge clk);
    checks++;
    if (adr_q.size() !== n || sent_q.size() !== n) begin
      errors++; $display("FAIL %s count: beats %0d accepted %0d expected %0d", name, adr_q.size(), sent_q.size(), n);
    end
    for (int i = 0; i < adr_q.size() && i < n && i < sent_q.size(); i++) begin
      exp_a = b + 32'(4 * i);
      exp_c = ((((i + 1) % bl) == 0) || (i == n - 1)) ? 3'b111 : 3'b010;
      checks++;
      if (adr_q[i] !== exp_a || dat_q[i] !== sent_q[i] || cti_q[i] !== exp_c) begin
        errors++;
        $display("FAIL %s beat%0d: adr %h dat %h cti %b expected adr %h dat %h cti %b",
                 name, i, adr_q[i], dat_q[i], cti_q[i], exp_a, sent_q[i], exp_c);
      end
    end
    checks++;
    if (bursts !== (n + bl - 1) / bl || done_cnt !== 1) begin
      errors++; $display("FAIL %s bursts: got %0d done %0d expected %0d done 1", name, bursts, done_cnt, (n + bl - 1) / bl);
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL %s protocol: %0d violations expected 0", name, viol); end
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({busy, done, rdy, cyc, stb, we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, rdy, cyc, stb, we});
    end
    checks++;
    if (adr !== 32'd0 || dat !== 32'd0 || sel !== 4'h0 || cti !== 3'b000) begin
      errors++; $display("FAIL reset_bus: adr %h dat %h sel %h cti %b expected zeros", adr, dat, sel, cti);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_partial_tail();
    run_xfer("partial_tail", 32'h0000_0100, 11, 0, 0, 1'b0);
    checks++;
    if (rdy !== 1'b0 || s_valid !== 1'b1 || sent_q.size() !== 11) begin
      errors++; $display("FAIL tail_ready: rdy %b valid %b accepted %0d expected 0 1 11", rdy, s_valid, sent_q.size());
    end
  endtask

  task automatic test_slow_slave();
    run_xfer("slow_slave", 32'h0000_4000, 40, 2, 0, 1'b0);
    checks++;
    if (saw_full !== 1'b1) begin errors++; $display("FAIL slow_full: saw_full %b expected 1", saw_full); end
  endtask

  task automatic test_zero_and_ignored_start();
    kick(32'h0000_0800, 0, 0, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: done %b busy %b expected 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_pulse: done %b expected 0", done); end
    repeat (10) @(negedge clk);
    checks++;
    if (bursts !== 0 || cyc !== 1'b0 || done_cnt !== 1) begin
      errors++; $display("FAIL zero_cyc: bursts %0d done_cnt %0d expected 0 1", bursts, done_cnt);
    end
    run_xfer("ignored_start", 32'h0000_1000, 30, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    int k = 0;
    kick(32'h0000_0300, 16, 2, 0);
    while (adr_q.size() < 3 && k < 500) begin @(negedge clk); k++; end
    @(posedge clk);
    #2;
    checks++;
    if (cyc !== 1'b1 || adr_q.size() !== 3) begin
      errors++; $display("FAIL rst_pre: cyc %b acks %0d expected 1 3", cyc, adr_q.size());
    end
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    checks++;
    if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0 || rdy !== 1'b0) begin
      errors++; $display("FAIL rst_async: cyc %b stb %b busy %b rdy %b expected 0000", cyc, stb, busy, rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    run_xfer("reset_restart", 32'h0000_0200, 6, 0, 1, 1'b0);
  endtask

  task automatic test_single_beat();
    use1 = 1'b1;
    run_xfer("single_beat", 32'h0000_0040, 3, 0, 0, 1'b0);
    run_xfer("single_beat_rand", 32'h0000_0080, 9, 1, 1, 1'b0);
    use1 = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      run_xfer("random", $urandom & 32'hFFFF_FFFC, $urandom_range(1, 37), $urandom_range(0, 2),
               $urandom_range(0, 1), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    run_xfer("single_burst", 32'h0000_0100, 8, 0, 0, 1'b0);
    test_partial_tail();
    test_slow_slave();
    test_zero_and_ignored_start();
    test_reset_mid_burst();
    run_xfer("addr_wrap", 32'hFFFF_FFF0, 10, 1, 1, 1'b0);
    test_single_beat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
